// File: rtl/hit_l1_pkg.sv
// Shared defaults and polarity/vote helpers for the redundant L1 hit buffer.
package hit_l1_pkg;

    localparam int WIDTH_D     = 1;
    localparam int ADDRWIDTH_D = 9;
    localparam int COPIES_D    = 4;
    localparam int ERRCNTW_D   = 8;

    localparam int VOTE_THR_D  = COPIES_D / 2;

    // Odd copies are stored inverted; XOR is its own inverse, so this
    // both encodes on write and restores true polarity on read.
    function automatic logic pol_inv(input int k);
        return k[0];
    endfunction

    function automatic int vote_thr(input int copies);
        return copies / 2;
    endfunction

endpackage

// File: rtl/hit_vote.sv
// Per-bit majority voter over COPIES mixed-polarity replicas.
module hit_vote
    import hit_l1_pkg::*;
#(
    parameter int WIDTH  = WIDTH_D,
    parameter int COPIES = COPIES_D
) (
    input  logic [COPIES*WIDTH-1:0] i_copies,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_err,
    output logic                    o_uncorr
);

    localparam int THR = vote_thr(COPIES);

    int w_ones;

    always_comb begin
        o_data   = '0;
        o_err    = 1'b0;
        o_uncorr = 1'b0;
        w_ones   = 0;
        for (int b = 0; b < WIDTH; b++) begin
            w_ones = 0;
            for (int k = 0; k < COPIES; k++) begin
                if (i_copies[k*WIDTH+b] ^ pol_inv(k)) begin
                    w_ones = w_ones + 1;
                end
            end
            o_data[b] = (w_ones > THR);
            if (2 * w_ones == COPIES) begin
                o_uncorr = 1'b1;
            end
            if (w_ones != 0 && w_ones != COPIES) begin
                o_err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hit_l1_buffer.sv
// Circular hit buffer with latency-relative L1 readout and redundant voting.
module hit_l1_buffer
    import hit_l1_pkg::*;
#(
    parameter int WIDTH     = WIDTH_D,
    parameter int ADDRWIDTH = ADDRWIDTH_D,
    parameter int COPIES    = COPIES_D,
    parameter int ERRCNTW   = ERRCNTW_D
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [WIDTH-1:0]     hitIn,
    input  logic                 wrEn,
    input  logic [ADDRWIDTH-1:0] l1Latency,
    input  logic                 l1a,
    input  logic [COPIES-1:0]    injectErr,
    input  logic                 clrErr,
    output logic [WIDTH-1:0]     dout,
    output logic                 doutValid,
    output logic                 errFlag,
    output logic                 uncorrFlag,
    output logic [ERRCNTW-1:0]   errCount,
    output logic [ADDRWIDTH-1:0] wrPtr
);

    localparam int DEPTH = 1 << ADDRWIDTH;
    localparam int MW    = COPIES * WIDTH;

    logic [MW-1:0]        r_mem [DEPTH];
    logic [MW-1:0]        r_rdData;
    logic                 r_rdValid;
    logic [ADDRWIDTH-1:0] r_wrPtr;
    logic [ERRCNTW-1:0]   r_errCount;

    logic [MW-1:0]        w_wrWord;
    logic [ADDRWIDTH-1:0] w_rdAddr;
    logic [WIDTH-1:0]     w_vote;
    logic                 w_err;
    logic                 w_uncorr;

    always_comb begin
        w_wrWord = '0;
        for (int k = 0; k < COPIES; k++) begin
            w_wrWord[k*WIDTH +: WIDTH] =
                hitIn ^ {WIDTH{pol_inv(k) ^ injectErr[k]}};
        end
    end

    assign w_rdAddr = r_wrPtr - l1Latency;

    // Storage array: no reset, so it maps onto an SRAM macro.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            r_mem[r_wrPtr] <= w_wrWord;
        end
    end

    // Registered read port; non-blocking read gives read-before-write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= l1a;
            if (l1a) begin
                r_rdData <= r_mem[w_rdAddr];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wrPtr <= '0;
        end else if (wrEn) begin
            r_wrPtr <= r_wrPtr + 1'b1;
        end
    end

    hit_vote #(
        .WIDTH  (WIDTH),
        .COPIES (COPIES)
    ) u_vote (
        .i_copies (r_rdData),
        .o_data   (w_vote),
        .o_err    (w_err),
        .o_uncorr (w_uncorr)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_errCount <= '0;
        end else if (clrErr) begin
            r_errCount <= '0;
        end else if (r_rdValid && w_err && r_errCount != '1) begin
            r_errCount <= r_errCount + 1'b1;
        end
    end

    // All-zero reset data votes to 0, so dout resets to 0 as well.
    assign dout       = w_vote;
    assign doutValid  = r_rdValid;
    assign errFlag    = r_rdValid & w_err;
    assign uncorrFlag = r_rdValid & w_uncorr;
    assign errCount   = r_errCount;
    assign wrPtr      = r_wrPtr;

endmodule

// File: tb/tb_hit_l1_buffer.sv
// Directed self-checking bench for hit_l1_buffer at default parameters.
module tb_hit_l1_buffer;

    logic       clk = 1'b0;
    logic       rstn;
    logic [0:0] hitIn;
    logic       wrEn;
    logic [8:0] l1Latency;
    logic       l1a;
    logic [3:0] injectErr;
    logic       clrErr;
    logic [0:0] dout;
    logic       doutValid;
    logic       errFlag;
    logic       uncorrFlag;
    logic [7:0] errCount;
    logic [8:0] wrPtr;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    hit_l1_buffer dut (
        .clk        (clk),
        .rstn       (rstn),
        .hitIn      (hitIn),
        .wrEn       (wrEn),
        .l1Latency  (l1Latency),
        .l1a        (l1a),
        .injectErr  (injectErr),
        .clrErr     (clrErr),
        .dout       (dout),
        .doutValid  (doutValid),
        .errFlag    (errFlag),
        .uncorrFlag (uncorrFlag),
        .errCount   (errCount),
        .wrPtr      (wrPtr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; hitIn = '0; wrEn = 1'b0; l1Latency = '0;
        l1a = 1'b0; injectErr = '0; clrErr = 1'b0;
        tick(); tick();
        chk("rst_wrPtr", 32'(wrPtr), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valid", 32'(doutValid), 0);
        chk("rst_err", 32'(errFlag), 0);
        chk("rst_uncorr", 32'(uncorrFlag), 0);
        chk("rst_errCount", 32'(errCount), 0);

        rstn = 1'b1; wrEn = 1'b1; l1Latency = 9'd10;
        for (int c = 0; c < 600; c++) begin
            hitIn = 1'(c % 2);
            tick();
        end
        chk("pat_wrPtr", 32'(wrPtr), 88);

        hitIn = 1'b0; l1a = 1'b1; tick();
        chk("lat10_valid", 32'(doutValid), 1);
        chk("lat10_dout", 32'(dout), 0);
        chk("lat10_err", 32'(errFlag), 0);
        chk("lat10_uncorr", 32'(uncorrFlag), 0);
        hitIn = 1'b1; tick();
        chk("b2b_valid", 32'(doutValid), 1);
        chk("b2b_dout", 32'(dout), 1);
        hitIn = 1'b0; l1a = 1'b0; tick();
        chk("idle_valid", 32'(doutValid), 0);
        chk("idle_hold", 32'(dout), 1);
        chk("idle_err", 32'(errFlag), 0);

        repeat (419) tick();
        chk("run_wrPtr", 32'(wrPtr), 510);
        hitIn = 1'b1; tick();
        hitIn = 1'b0; tick();
        hitIn = 1'b1; tick();
        hitIn = 1'b1; tick();
        hitIn = 1'b0; tick();
        chk("wrap_wrPtr", 32'(wrPtr), 3);
        l1Latency = 9'd5; l1a = 1'b1; tick();
        chk("wrap_510", 32'(dout), 1);
        tick();
        chk("wrap_511", 32'(dout), 0);
        tick();
        chk("wrap_000", 32'(dout), 1);
        chk("wrap_valid", 32'(doutValid), 1);
        l1a = 1'b0; tick();

        l1Latency = 9'd0; l1a = 1'b1; tick();
        chk("coll_old", 32'(dout), 1);
        l1Latency = 9'd1; tick();
        chk("coll_new", 32'(dout), 0);
        chk("coll_wrPtr", 32'(wrPtr), 9);

        l1a = 1'b0; hitIn = 1'b1; injectErr = 4'b0001; tick();
        injectErr = '0; hitIn = 1'b0; l1a = 1'b1; tick();
        chk("inj1_dout", 32'(dout), 1);
        chk("inj1_err", 32'(errFlag), 1);
        chk("inj1_uncorr", 32'(uncorrFlag), 0);
        l1a = 1'b0; tick();
        chk("inj1_cnt", 32'(errCount), 1);

        hitIn = 1'b1; injectErr = 4'b0011; tick();
        injectErr = '0; hitIn = 1'b0; l1a = 1'b1; tick();
        chk("tie_dout", 32'(dout), 0);
        chk("tie_err", 32'(errFlag), 1);
        chk("tie_uncorr", 32'(uncorrFlag), 1);
        l1a = 1'b0; tick();
        chk("tie_cnt", 32'(errCount), 2);

        hitIn = 1'b0; injectErr = 4'b0010; tick();
        injectErr = '0; l1a = 1'b1; tick();
        chk("odd_dout", 32'(dout), 0);
        chk("odd_err", 32'(errFlag), 1);
        chk("odd_uncorr", 32'(uncorrFlag), 0);
        l1a = 1'b0; tick();
        chk("odd_cnt", 32'(errCount), 3);

        hitIn = 1'b1; injectErr = 4'b0001; tick();
        injectErr = '0; hitIn = 1'b0; wrEn = 1'b0; l1a = 1'b1;
        repeat (300) tick();
        chk("frz_wrPtr", 32'(wrPtr), 19);
        chk("frz_dout", 32'(dout), 1);
        chk("frz_err", 32'(errFlag), 1);
        l1a = 1'b0; tick(); tick();
        chk("sat_cnt", 32'(errCount), 255);
        l1a = 1'b1; tick();
        l1a = 1'b0; tick(); tick();
        chk("sat_hold", 32'(errCount), 255);

        l1a = 1'b1; tick();
        chk("clr_err", 32'(errFlag), 1);
        clrErr = 1'b1; l1a = 1'b0; tick();
        chk("clr_wins", 32'(errCount), 0);
        clrErr = 1'b0; tick();
        chk("clr_stay", 32'(errCount), 0);
        l1a = 1'b1; tick();
        l1a = 1'b0; tick(); tick();
        chk("recnt", 32'(errCount), 1);

        l1a = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        tick();
        chk("mrst_valid", 32'(doutValid), 0);
        chk("mrst_dout", 32'(dout), 0);
        chk("mrst_err", 32'(errFlag), 0);
        chk("mrst_cnt", 32'(errCount), 0);
        chk("mrst_wrPtr", 32'(wrPtr), 0);
        l1a = 1'b0; tick();
        chk("mrst_valid2", 32'(doutValid), 0);
        rstn = 1'b1; tick();
        chk("post_valid", 32'(doutValid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
